// File: rtl/imuldiv_three_mul_arbiter.sv
// Round-robin arbiter sharing one three-input multiplier between two val/rdy clients.
// An owner-tag FIFO remembers who issued each in-flight request so results route back in order.
module imuldiv_three_mul_arbiter #(
    parameter int p_max_outstanding = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [98:0] req0_msg,
    input  logic        req0_val,
    output logic        req0_rdy,
    input  logic [98:0] req1_msg,
    input  logic        req1_val,
    output logic        req1_rdy,

    output logic [95:0] resp0_msg,
    output logic        resp0_val,
    input  logic        resp0_rdy,
    output logic [95:0] resp1_msg,
    output logic        resp1_val,
    input  logic        resp1_rdy,

    output logic [2:0]  mulreq_msg_fn,
    output logic [31:0] mulreq_msg_a,
    output logic [31:0] mulreq_msg_b,
    output logic [31:0] mulreq_msg_c,
    output logic        mulreq_val,
    input  logic        mulreq_rdy,

    input  logic [95:0] mulresp_msg_result,
    input  logic        mulresp_val,
    output logic        mulresp_rdy,

    output logic [3:0]  dbg_count_o,
    output logic [2:0]  dbg_head_o,
    output logic [2:0]  dbg_tail_o,
    output logic        dbg_prio_o,
    output logic        dbg_lock_o,
    output logic        dbg_lock_id_o
);

    // Handshake: a transfer happens on a channel in any cycle where val & rdy are both high.
    localparam logic [3:0] MAX_CNT = 4'(p_max_outstanding);
    localparam logic [2:0] LAST_PTR = 3'(p_max_outstanding - 1);

    logic [3:0]  count_q, count_d;
    logic [2:0]  head_q, head_d, tail_q, tail_d;
    logic        prio_q, prio_d, lock_q, lock_d, lock_id_q, lock_id_d;
    logic        owner_q [0:7];

    logic        can_issue, gnt_val, gnt_id, gnt_req_val;
    logic        has_out, head_id, issue_fire, resp_fire;
    logic [98:0] gnt_msg;

    function automatic logic [2:0] ptr_inc(input logic [2:0] p);
        return (p == LAST_PTR) ? 3'd0 : p + 3'd1;
    endfunction

    // A stalled issue keeps its grant so the multiplier sees a stable message.
    always_comb begin
        gnt_val = 1'b0;
        gnt_id  = prio_q;
        if (lock_q) begin
            gnt_val = 1'b1;
            gnt_id  = lock_id_q;
        end else if (req0_val && req1_val) begin
            gnt_val = 1'b1;
            gnt_id  = prio_q;
        end else if (req0_val || req1_val) begin
            gnt_val = 1'b1;
            gnt_id  = req1_val;
        end
    end

    // Gated with reset so every handshake output is quiet while reset is held.
    assign can_issue   = ~reset & (count_q < MAX_CNT);
    assign gnt_req_val = gnt_id ? req1_val : req0_val;
    assign gnt_msg     = gnt_id ? req1_msg : req0_msg;

    assign mulreq_val    = can_issue & gnt_val & gnt_req_val;
    assign mulreq_msg_fn = gnt_msg[98:96];
    assign mulreq_msg_a  = gnt_msg[95:64];
    assign mulreq_msg_b  = gnt_msg[63:32];
    assign mulreq_msg_c  = gnt_msg[31:0];
    assign req0_rdy      = can_issue & gnt_val & ~gnt_id & mulreq_rdy;
    assign req1_rdy      = can_issue & gnt_val &  gnt_id & mulreq_rdy;
    assign issue_fire    = mulreq_val & mulreq_rdy;

    assign has_out     = ~reset & (count_q != 4'd0);
    assign head_id     = owner_q[head_q];
    assign resp0_val   = mulresp_val & has_out & ~head_id;
    assign resp1_val   = mulresp_val & has_out &  head_id;
    assign resp0_msg   = mulresp_msg_result;
    assign resp1_msg   = mulresp_msg_result;
    assign mulresp_rdy = has_out & (head_id ? resp1_rdy : resp0_rdy);
    assign resp_fire   = mulresp_val & mulresp_rdy;

    always_comb begin
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;
        prio_d    = prio_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (issue_fire) begin
            tail_d = ptr_inc(tail_q);
            prio_d = ~gnt_id;
            lock_d = 1'b0;
        end else if (mulreq_val) begin
            lock_d    = 1'b1;
            lock_id_d = gnt_id;
        end
        if (resp_fire) head_d = ptr_inc(head_q);
        case ({issue_fire, resp_fire})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 4'd0;
            head_q    <= 3'd0;
            tail_q    <= 3'd0;
            prio_q    <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            prio_q    <= prio_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Tag storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (issue_fire) owner_q[tail_q] <= gnt_id;
    end

    assign dbg_count_o   = count_q;
    assign dbg_head_o    = head_q;
    assign dbg_tail_o    = tail_q;
    assign dbg_prio_o    = prio_q;
    assign dbg_lock_o    = lock_q;
    assign dbg_lock_id_o = lock_id_q;

endmodule

// File: tb/tb_imuldiv_three_mul_arbiter.sv
// Bench for imuldiv_three_mul_arbiter: directed scenarios plus a random phase, checked
// against queue-based owner/result bookkeeping and a behavioural in-order multiplier.
module tb_imuldiv_three_mul_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [98:0] req0_msg, req1_msg;
    logic        req0_val, req1_val, req0_rdy, req1_rdy;
    logic [95:0] resp0_msg, resp1_msg;
    logic        resp0_val, resp1_val, resp0_rdy, resp1_rdy;
    logic [2:0]  mulreq_msg_fn;
    logic [31:0] mulreq_msg_a, mulreq_msg_b, mulreq_msg_c;
    logic        mulreq_val, mulreq_rdy;
    logic [95:0] mulresp_msg_result;
    logic        mulresp_val, mulresp_rdy;
    logic [3:0]  dbg_count_o;
    logic [2:0]  dbg_head_o, dbg_tail_o;
    logic        dbg_prio_o, dbg_lock_o, dbg_lock_id_o;

    imuldiv_three_mul_arbiter #(.p_max_outstanding(MAX)) dut (
        .clk(clk), .reset(reset),
        .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .mulreq_msg_fn(mulreq_msg_fn), .mulreq_msg_a(mulreq_msg_a),
        .mulreq_msg_b(mulreq_msg_b), .mulreq_msg_c(mulreq_msg_c),
        .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
        .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
        .mulresp_rdy(mulresp_rdy),
        .dbg_count_o(dbg_count_o), .dbg_head_o(dbg_head_o), .dbg_tail_o(dbg_tail_o),
        .dbg_prio_o(dbg_prio_o), .dbg_lock_o(dbg_lock_o), .dbg_lock_id_o(dbg_lock_id_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [95:0] r;
        int          t;
    } mp_t;

    mp_t         mpipe[$];
    logic        own_q[$];
    logic [95:0] exp_q0[$], exp_q1[$];
    int          issue_log[$], issue_cyc[$], resp_log[$];
    int          resp_cnt0, resp_cnt1, iss0, iss1, first_pop;
    logic        saw_resp1_val, fired0, fired1;
    logic [95:0] last_resp0, last_resp1;
    logic        m_prio, m_lock, m_lock_id;
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    logic        mresp_en = 1'b1;
    logic [95:0] neg35 = -96'sd35;

    task automatic chk(input string tag, input logic [98:0] obs, input logic [98:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mulf(input logic [98:0] m);
        logic signed [95:0] a, b, c;
        a = {{64{m[95]}}, m[95:64]};
        b = {{64{m[63]}}, m[63:32]};
        c = {{64{m[31]}}, m[31:0]};
        return a * b * c;
    endfunction

    function automatic logic [98:0] mk(input logic [2:0] fn, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] c);
        return {fn, a, b, c};
    endfunction

    task automatic clear_logs();
        issue_log.delete(); issue_cyc.delete(); resp_log.delete();
        resp_cnt0 = 0; resp_cnt1 = 0; iss0 = 0; iss1 = 0; first_pop = -1;
        saw_resp1_val = 1'b0;
    endtask

    // Compare the DUT against the expected behaviour just before the rising edge.
    task automatic sample();
        int sz;
        logic w, ok, can, mv, hv, h, hr, rf;
        logic [98:0] wmsg;
        logic [95:0] e;
        fired0 = 1'b0;
        fired1 = 1'b0;
        if (reset) begin
            chk("rst_req0_rdy", 99'(req0_rdy), 99'(0));
            chk("rst_req1_rdy", 99'(req1_rdy), 99'(0));
            chk("rst_mulreq_val", 99'(mulreq_val), 99'(0));
            chk("rst_resp0_val", 99'(resp0_val), 99'(0));
            chk("rst_resp1_val", 99'(resp1_val), 99'(0));
            chk("rst_mulresp_rdy", 99'(mulresp_rdy), 99'(0));
            own_q.delete(); exp_q0.delete(); exp_q1.delete(); mpipe.delete();
            m_prio = 1'b0; m_lock = 1'b0; m_lock_id = 1'b0;
            return;
        end
        sz = own_q.size();
        chk("count", 99'(dbg_count_o), 99'(sz));
        ok = 1'b1;
        w  = 1'b0;
        if (m_lock) w = m_lock_id;
        else if (req0_val && req1_val) w = m_prio;
        else if (req0_val || req1_val) w = req1_val;
        else ok = 1'b0;
        can  = (sz < MAX);
        wmsg = w ? req1_msg : req0_msg;
        mv   = can && ok && (w ? req1_val : req0_val);
        chk("mulreq_val", 99'(mulreq_val), 99'(mv));
        chk("req0_rdy", 99'(req0_rdy), 99'(can && ok && !w && mulreq_rdy));
        chk("req1_rdy", 99'(req1_rdy), 99'(can && ok && w && mulreq_rdy));
        if (mv) chk("mulreq_msg", {mulreq_msg_fn, mulreq_msg_a, mulreq_msg_b, mulreq_msg_c}, wmsg);

        hv = (sz > 0);
        h  = hv ? own_q[0] : 1'b0;
        hr = h ? resp1_rdy : resp0_rdy;
        chk("resp0_val", 99'(resp0_val), 99'(mulresp_val && hv && !h));
        chk("resp1_val", 99'(resp1_val), 99'(mulresp_val && hv && h));
        chk("mulresp_rdy", 99'(mulresp_rdy), 99'(hv && hr));
        chk("resp0_msg", 99'(resp0_msg), 99'(mulresp_msg_result));
        chk("resp1_msg", 99'(resp1_msg), 99'(mulresp_msg_result));
        if (resp1_val) saw_resp1_val = 1'b1;
        rf = mulresp_val && hv && hr;
        if (rf) begin
            e = h ? exp_q1.pop_front() : exp_q0.pop_front();
            chk(h ? "resp1_data" : "resp0_data", 99'(h ? resp1_msg : resp0_msg), 99'(e));
            void'(own_q.pop_front());
            void'(mpipe.pop_front());
            resp_log.push_back(int'(h));
            if (first_pop < 0) first_pop = cyc;
            if (h) begin resp_cnt1++; last_resp1 = resp1_msg; end
            else   begin resp_cnt0++; last_resp0 = resp0_msg; end
        end
        if (mv && mulreq_rdy) begin
            own_q.push_back(w);
            if (w) exp_q1.push_back(mulf(wmsg));
            else   exp_q0.push_back(mulf(wmsg));
            mpipe.push_back('{mulf({mulreq_msg_fn, mulreq_msg_a, mulreq_msg_b, mulreq_msg_c}),
                              cyc + int'($urandom_range(lat_max, lat_min))});
            issue_log.push_back(int'(w));
            issue_cyc.push_back(cyc);
            if (w) begin iss1++; fired1 = 1'b1; end
            else   begin iss0++; fired0 = 1'b1; end
            m_prio = !w;
            m_lock = 1'b0;
        end else if (mv) begin
            m_lock    = 1'b1;
            m_lock_id = w;
        end
    endtask

    // Behavioural multiplier: returns results in issue order after their latency.
    task automatic drive_mul();
        if (mpipe.size() > 0 && mpipe[0].t <= cyc && mresp_en) begin
            mulresp_val        = 1'b1;
            mulresp_msg_result = mpipe[0].r;
        end else begin
            mulresp_val        = 1'b0;
            mulresp_msg_result = {$urandom, $urandom, $urandom};
        end
    endtask

    task automatic step();
        #4;
        sample();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        drive_mul();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; req0_val = 1'b0; req1_val = 1'b0;
        repeat (n) step();
        chk("rst_count", 99'(dbg_count_o), 99'(0));
        chk("rst_head", 99'(dbg_head_o), 99'(0));
        chk("rst_tail", 99'(dbg_tail_o), 99'(0));
        chk("rst_prio", 99'(dbg_prio_o), 99'(0));
        chk("rst_lock", 99'(dbg_lock_o), 99'(0));
        reset = 1'b0;
        lat_min = 1; lat_max = 1; mresp_en = 1'b1;
        mulreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        clear_logs();
    endtask

    task automatic wait_cnt(input string tag, input int n0, input int n1, input int limit);
        int k = 0;
        while ((resp_cnt0 < n0 || resp_cnt1 < n1) && k < limit) begin
            step();
            k++;
        end
        chk(tag, 99'(resp_cnt0 >= n0 && resp_cnt1 >= n1), 99'(1));
    endtask

    initial begin
        reset = 1'b1; req0_val = 1'b0; req1_val = 1'b0;
        req0_msg = '0; req1_msg = '0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1; mulreq_rdy = 1'b1;
        drive_mul();
        do_reset(2);

        // Single requester
        req0_msg = mk(3'd0, 32'h2, 32'h3, 32'h5); req0_val = 1'b1;
        step();
        req0_val = 1'b0;
        wait_cnt("t1_wait", 1, 0, 10);
        chk("t1_result", 99'(last_resp0), 99'(96'h1e));
        chk("t1_no_resp1", 99'(saw_resp1_val), 99'(0));
        chk("t1_prio", 99'(dbg_prio_o), 99'(1));

        // Contention, alternating grants
        do_reset(1);
        req0_msg = mk(3'd1, 32'h7fffffff, 32'h7fffffff, 32'h1);
        req1_msg = mk(3'd2, 32'h80000000, 32'h80000000, 32'h1);
        for (int k = 0; k < 40 && issue_log.size() < 8; k++) begin
            req0_val = (iss0 < 4);
            req1_val = (iss1 < 4);
            step();
        end
        req0_val = 1'b0; req1_val = 1'b0;
        wait_cnt("t2_wait", 4, 4, 20);
        chk("t2_issues", 99'(issue_log.size()), 99'(8));
        for (int i = 0; i < issue_log.size(); i++)
            chk($sformatf("t2_order%0d", i), 99'(issue_log[i]), 99'(i % 2));
        chk("t2_resp0", 99'(last_resp0), 99'(96'h000000003fffffff00000001));
        chk("t2_resp1", 99'(last_resp1), 99'(96'h000000004000000000000000));

        // Outstanding limit
        do_reset(1);
        resp0_rdy = 1'b0;
        req0_msg = mk(3'd3, 32'h5, 32'h7, 32'hffffffff); req0_val = 1'b1;
        repeat (8) step();
        chk("t3_issued", 99'(iss0), 99'(4));
        chk("t3_count", 99'(dbg_count_o), 99'(4));
        chk("t3_req0_rdy", 99'(req0_rdy), 99'(0));
        resp0_rdy = 1'b1;
        for (int k = 0; k < 10 && iss0 < 5; k++) step();
        req0_val = 1'b0;
        chk("t3_issue5_seen", 99'(issue_cyc.size()), 99'(5));
        if (issue_cyc.size() >= 5) chk("t3_issue5_cycle", 99'(issue_cyc[4]), 99'(first_pop + 1));
        wait_cnt("t3_wait", 5, 0, 20);
        chk("t3_result", 99'(last_resp0), 99'(neg35));

        // Grant lock against a competing requester that would otherwise win on priority
        do_reset(1);
        req0_msg = mk(3'd4, 32'd11, 32'd13, 32'd17); req0_val = 1'b1;
        step();
        req0_val = 1'b0;
        wait_cnt("t4_pre", 1, 0, 10);
        chk("t4_prio", 99'(dbg_prio_o), 99'(1));
        clear_logs();
        mulreq_rdy = 1'b0;
        req0_msg = mk(3'd5, 32'd3, 32'd4, 32'd5); req0_val = 1'b1;
        req1_msg = mk(3'd6, 32'd6, 32'd7, 32'd8);
        step();
        req1_val = 1'b1;
        step();
        chk("t4_lock", 99'(dbg_lock_o), 99'(1));
        chk("t4_hold_msg", {mulreq_msg_fn, mulreq_msg_a, mulreq_msg_b, mulreq_msg_c}, req0_msg);
        step();
        mulreq_rdy = 1'b1;
        step();
        req0_val = 1'b0;
        step();
        req1_val = 1'b0;
        chk("t4_issues", 99'(issue_log.size()), 99'(2));
        if (issue_log.size() == 2) begin
            chk("t4_first", 99'(issue_log[0]), 99'(0));
            chk("t4_second", 99'(issue_log[1]), 99'(1));
        end
        wait_cnt("t4_wait", 1, 1, 10);

        // Head-of-line blocking
        do_reset(1);
        resp0_rdy = 1'b0;
        req0_msg = mk(3'd0, 32'd1, 32'd2, 32'd3); req0_val = 1'b1;
        step();
        req0_val = 1'b0;
        req1_msg = mk(3'd0, 32'd4, 32'd5, 32'd6); req1_val = 1'b1;
        step();
        req1_val = 1'b0;
        repeat (5) step();
        chk("t5_no_resp1", 99'(resp_cnt1), 99'(0));
        chk("t5_resp1_val", 99'(saw_resp1_val), 99'(0));
        resp0_rdy = 1'b1;
        wait_cnt("t5_wait", 1, 1, 10);
        chk("t5_order_n", 99'(resp_log.size()), 99'(2));
        if (resp_log.size() == 2) begin
            chk("t5_order0", 99'(resp_log[0]), 99'(0));
            chk("t5_order1", 99'(resp_log[1]), 99'(1));
        end

        // Reset with requests outstanding
        do_reset(1);
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        req0_msg = mk(3'd0, 32'd9, 32'd9, 32'd9);
        req1_msg = mk(3'd0, 32'd8, 32'd8, 32'd8);
        req0_val = 1'b1; step(); req0_val = 1'b0;
        req1_val = 1'b1; step(); req1_val = 1'b0;
        req0_val = 1'b1; step(); req0_val = 1'b0;
        step();
        chk("t6_count3", 99'(dbg_count_o), 99'(3));
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        clear_logs();
        chk("t6_count0", 99'(dbg_count_o), 99'(0));
        req1_msg = mk(3'd0, 32'h1, 32'h16414511, 32'h1); req1_val = 1'b1;
        step();
        req1_val = 1'b0;
        wait_cnt("t6_wait", 0, 1, 10);
        repeat (5) step();
        chk("t6_result", 99'(last_resp1), 99'(96'h000000000000000016414511));
        chk("t6_no_stale", 99'(resp_cnt0), 99'(0));

        // Random traffic; an unaccepted request is held until it fires
        do_reset(1);
        lat_min = 1; lat_max = 3;
        for (int k = 0; k < 400; k++) begin
            if (!req0_val || fired0) begin
                req0_val = ($urandom_range(0, 1) == 1);
                req0_msg = {3'($urandom), $urandom, $urandom, $urandom};
            end
            if (!req1_val || fired1) begin
                req1_val = ($urandom_range(0, 1) == 1);
                req1_msg = {3'($urandom), $urandom, $urandom, $urandom};
            end
            mulreq_rdy = ($urandom_range(0, 3) != 0);
            resp0_rdy  = ($urandom_range(0, 3) != 0);
            resp1_rdy  = ($urandom_range(0, 3) != 0);
            mresp_en   = ($urandom_range(0, 3) != 0);
            step();
        end
        req0_val = 1'b0; req1_val = 1'b0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1; mresp_en = 1'b1;
        for (int k = 0; k < 50 && own_q.size() > 0; k++) step();
        step();
        chk("drain_empty", 99'(own_q.size()), 99'(0));
        chk("drain_count", 99'(dbg_count_o), 99'(0));
        chk("rand_activity", 99'(resp_cnt0 > 10 && resp_cnt1 > 10), 99'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
